// File: rtl/divider_pkg.sv
// Shared types and helpers for the multi-cycle radix-2 restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {PH_LOAD, PH_ITER, PH_DONE} phase_e;

  // Upper bound on supported XLEN; sext32 is sized to this and truncated at the call site.
  localparam int MAX_W = 128;

  function automatic int iterations(input logic word, input int width);
    return word ? 32 : width;
  endfunction

  function automatic logic [MAX_W-1:0] sext32(input logic [31:0] x);
    return {{(MAX_W-32){x[31]}}, x};
  endfunction

endpackage

// File: rtl/adder.sv
// Plain ripple/inferred adder with carry in and carry out.
module adder #(
  parameter int width = 64
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, cin};
endmodule

// File: rtl/divider_step.sv
// One restoring-division step: shift {rem, dvd} left, trial-subtract divisor, select.
module divider_step #(
  parameter int width = 64
) (
  input  logic [width:0]   rem,
  input  logic [width-1:0] dvd,
  input  logic [width-1:0] dvs,
  output logic [width:0]   rem_nxt,
  output logic [width-1:0] dvd_nxt
);
  logic [width:0] sh, diff;
  logic           no_borrow;
  logic           unused_rem_msb;

  // The partial remainder is always below the divisor, so its MSB is zero before the shift.
  assign unused_rem_msb = rem[width];
  assign sh = {rem[width-1:0], dvd[width-1]};

  adder #(.width(width+1)) u_sub (
    .a   (sh),
    .b   (~{1'b0, dvs}),
    .cin (1'b1),
    .sum (diff),
    .cout(no_borrow)
  );

  assign rem_nxt = no_borrow ? diff : sh;
  assign dvd_nxt = {dvd[width-2:0], no_borrow};
endmodule

// File: rtl/divider_multi_cycle.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/REM (and W variants), one bit per clock.
// DIVIDER_EARLY_OUT_EN: finish on the LOAD edge for divide-by-zero or |dividend| < |divisor|.
module divider_multi_cycle
  import divider_pkg::*;
#(
  parameter int width = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             word,
  input  logic             is_signed,
  input  logic [width-1:0] arg1,
  input  logic [width-1:0] arg2,
  output logic             busy,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder
);
  localparam int CW  = $clog2(width + 2);
  localparam int WSH = (width > 32) ? width - 32 : 0;

  logic [CW-1:0]    i, i_nxt;
  logic [width:0]   rem, rem_n;
  logic [width-1:0] dvd, dvd_n, dvs;
  logic             neg_q, neg_r, dz, word_q;
  phase_e           phase;
  logic             last, early;

  logic [width-1:0] a1x, a2x, mag1, mag2;
  logic             s1, s2;
  logic [width-1:0] q_m, q_s, r_m, r_s, q_res, r_res;

  function automatic logic [width-1:0] ext32(input logic [31:0] x);
    return width'(sext32(x));
  endfunction

  function automatic logic [width-1:0] extend(input logic [width-1:0] x, input logic w,
                                             input logic s);
    logic [31:0] lo;
    lo = 32'(x);
    if (!w) return x;
    return s ? ext32(lo) : width'(lo);
  endfunction

  // Operand conditioning, only consumed on the LOAD edge.
  always_comb begin
    a1x  = extend(arg1, word, is_signed);
    a2x  = extend(arg2, word, is_signed);
    s1   = is_signed & a1x[width-1];
    s2   = is_signed & a2x[width-1];
    mag1 = s1 ? -a1x : a1x;
    mag2 = s2 ? -a2x : a2x;
`ifdef DIVIDER_EARLY_OUT_EN
    early = (a2x == '0) || (mag1 < mag2);
`else
    early = 1'b0;
`endif
  end

  always_comb begin
    phase = PH_ITER;
    if (i == '0)                                    phase = PH_LOAD;
    else if (i == CW'(iterations(word_q, width) + 1)) phase = PH_DONE;
    last = (phase == PH_ITER) && (i == CW'(iterations(word_q, width)));
    busy = start && (phase != PH_DONE);
  end

  always_comb begin
    i_nxt = i;
    if (!start) i_nxt = '0;
    else begin
      unique case (phase)
        PH_LOAD: i_nxt = early ? CW'(iterations(word, width) + 1) : CW'(1);
        PH_ITER: i_nxt = i + CW'(1);
        default: i_nxt = i;
      endcase
    end
  end

  divider_step #(.width(width)) u_step (
    .rem    (rem),
    .dvd    (dvd),
    .dvs    (dvs),
    .rem_nxt(rem_n),
    .dvd_nxt(dvd_n)
  );

  // Sign fixup; word results are sign-extended from bit 31 even for unsigned ops.
  always_comb begin
    q_m   = word_q ? width'(dvd_n[31:0]) : dvd_n;
    q_s   = neg_q ? -q_m : q_m;
    r_m   = rem_n[width-1:0];
    r_s   = neg_r ? -r_m : r_m;
    q_res = dz ? '1 : (word_q ? ext32(q_s[31:0]) : q_s);
    r_res = word_q ? ext32(r_s[31:0]) : r_s;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i         <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      word_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      i <= i_nxt;
      if (start) begin
        unique case (phase)
          PH_LOAD: begin
            rem    <= '0;
            // Word dividends sit in the top 32 bits so bit 31 is the first shifted out.
            dvd    <= word ? (mag1 << WSH) : mag1;
            dvs    <= mag2;
            neg_q  <= s1 ^ s2;
            neg_r  <= s1;
            dz     <= (a2x == '0);
            word_q <= word;
`ifdef DIVIDER_EARLY_OUT_EN
            if (early) begin
              quotient  <= (a2x == '0) ? '1 : '0;
              remainder <= word ? ext32(32'(arg1)) : arg1;
            end
`endif
          end
          PH_ITER: begin
            rem <= rem_n;
            dvd <= dvd_n;
            if (last) begin
              quotient  <= q_res;
              remainder <= r_res;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/divider_multi_cycle.md
# divider_multi_cycle

Multi-cycle radix-2 restoring integer divider for the M-extension DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW operations. It is the inverse-operation companion to the multi-cycle Booth multiplier and uses the same level-held `start` / `busy` handshake, so the execute stage drives both units identically. It retires one quotient bit per clock and produces quotient and remainder together with RISC-V-defined results for division by zero and signed overflow.

## Interface
- `width`, default 64: XLEN; must be even and at least 4.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: reset is asynchronous and active-high; clears every register.
- `start`  in  1: level request; held high for the whole operation and until the result is consumed.
- `word`  in  1: W-op; operates on `arg[31:0]`, and results are sign-extended from bit 31.
- `is_signed`  in  1: signed division (DIV/REM); otherwise unsigned.
- `arg1`  in  `width`: dividend.
- `arg2`  in  `width`: divisor.
- `busy`  out  1: `start & (i != N+1)`; combinational.
- `quotient`  out  `width`: registered; reset value 0.
- `remainder`  out  `width`: registered; reset value 0.

## Operation
- N is the iteration count: N = 32 if `word`, otherwise `width`. The counter `i` is `$clog2(width+2)` bits wide, and its reset value is 0.
- There are three phases, keyed on `i`:
  - LOAD (`i == 0`):
    - Operands are sampled only here. In word mode they are taken from bits [31:0], sign- or zero-extended per `is_signed`.
    - The unit stores the magnitudes, the dividend sign and the quotient sign (the sign XOR, valid only when signed). It latches `word`, zeroes the partial remainder (N+1 bits), and sets `i <= 1`.
  - ITER (`1 <= i <= N`):
    - Shift {partial remainder, dividend} left by 1.
    - Trial-subtract the divisor magnitude from the upper part. If there is no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
    - `i <= i + 1`.
  - DONE (`i == N+1`):
    - `i` holds while `start` stays high.
    - `busy` is low, and `quotient` / `remainder` are stable.
- Result write happens on the edge that performs iteration N:
  - The quotient is negated if the quotient sign is set.
  - The remainder is negated if the dividend is negative.
  - In word mode both results are sign-extended from bit 31, including the unsigned case.
- Divide by zero: the quotient is all ones and the remainder equals the (word-extended) dividend. The special-case flag set at LOAD forces this regardless of signs.
- Signed overflow (most-negative / −1): the quotient equals the dividend and the remainder is 0. The magnitude datapath produces this naturally; no special case is needed.
- Operand changes after LOAD are ignored.
- `start` low at a clock edge:
  - Sets `i <= 0` from any phase.
  - Results hold their last values.
  - An operation abandoned mid-ITER leaves `quotient` / `remainder` unchanged.
- A new operation requires at least one edge with `start` low between requests.

## Timing
- Full width: `busy` falls after 1 + width rising edges with `start` high (65 at width 64).
- Word mode: `busy` falls after 33 edges.
- `busy` rises combinationally in the same cycle `start` rises (since `i == 0`).
- Results are valid in the same cycle `busy` falls.
- Asynchronous reset asserted mid-operation:
  - `i`, operand registers, `quotient` and `remainder` clear to 0 immediately.
  - If `start` is high, `busy` reads 1.
  - After release, the operation restarts from LOAD on the next edge.

## Configuration
- `DIVIDER_EARLY_OUT_EN` defined:
  - At LOAD, if the divisor is zero or |dividend| < |divisor| (unsigned magnitude compare over N bits), the final results are written on the LOAD edge and `i <= N+1`.
  - `busy` falls after 1 edge. For the |dividend| < |divisor| case, the quotient is 0 and the remainder is the dividend.
- `DIVIDER_EARLY_OUT_EN` undefined: every operation takes the full 1 + N edges, and there is no magnitude comparator.

## Structure
- Package `divider_pkg`:
  - A phase enum (LOAD / ITER / DONE) decoded from `i`, for readability and assertions.
  - A function `iterations(word, width)`.
  - A function `sext32(x)` that sign-extends a 32-bit result to `width`.
- Sub-module `divider_step`:
  - Combinational; performs one shift / trial-subtract / select.
  - Inputs: partial remainder, dividend, divisor magnitude. Outputs: next partial remainder, next dividend / quotient.
  - The trial subtract uses the codebase's existing `adder` module with `cin = 1` and the divisor inverted.

## Test plan
- Unsigned 100 / 7, width 64:
  - `busy` is 1 for 65 edges, then 0.
  - `quotient` = 14, `remainder` = 2.
- Signed −7 / 2 (arg1 = 0xFFFFFFFFFFFFFFF9):
  - `quotient` = 0xFFFFFFFFFFFFFFFD, `remainder` = 0xFFFFFFFFFFFFFFFF.
- Signed 0x1234 / 0:
  - `quotient` = 0xFFFFFFFFFFFFFFFF, `remainder` = 0x1234.
  - With `DIVIDER_EARLY_OUT_EN`, `busy` falls after 1 edge.
- Signed 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF:
  - `quotient` = 0x8000000000000000, `remainder` = 0 after 65 edges.
- Word mode, 33 edges each:
  - Signed 0x0000000080000000 / 0xFFFFFFFFFFFFFFFF gives `quotient` = 0xFFFFFFFF80000000, `remainder` = 0.
  - Unsigned 0x00000000FFFFFFFE / 2 gives `quotient` = 0x000000007FFFFFFF, `remainder` = 0.
- Pulse `reset` after 10 edges of 100 / 7 with `start` held high:
  - `quotient` / `remainder` read 0 immediately and `busy` stays 1.
  - After release, a full 65 edges are required, then 14 / 2.
